// File: rtl/alu_issuer.sv
// ALU operand issuer: registers commands onto the ALU ports, waits SETTLE cycles, captures results into a FWFT FIFO.
// Optional ALU_ISSUER_CHAIN_EN adds cmd_chain, which sources num2 from the previously captured result.
module alu_issuer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [31:0]      cmd_b,
`ifdef ALU_ISSUER_CHAIN_EN
    input  logic             cmd_chain,
`endif
    output logic [7:0]       alu_num1,
    output logic [31:0]      alu_num2,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(DEPTH);
    localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       num1_q, num1_d;
    logic [31:0]      num2_q, num2_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [32:0]      mem_q [DEPTH];
    logic             push, pop;
`ifdef ALU_ISSUER_CHAIN_EN
    logic [31:0]      last_q, last_d;
`endif

    always_comb begin
        state_d   = state_q;
        num1_d    = num1_q;
        num2_d    = num2_q;
        op_d      = op_q;
        err_d     = err_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        pop       = (count_q != '0) && res_ready;
        cmd_ready = rst_n && (state_q == IDLE) && (count_q < DEPTH_C);

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    num1_d   = cmd_a;
`ifdef ALU_ISSUER_CHAIN_EN
                    num2_d   = cmd_chain ? last_q : cmd_b;
`else
                    num2_d   = cmd_b;
`endif
                    op_d     = cmd_op;
                    err_d    = (cmd_op >= 3'b110);
                    settle_d = SETTLE_M1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (settle_q == '0) begin
                    push    = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        // A simultaneous push and pop leaves occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
`ifdef ALU_ISSUER_CHAIN_EN
        last_d = push ? alu_out : last_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            num1_q   <= '0;
            num2_q   <= '0;
            op_q     <= '0;
            err_q    <= 1'b0;
            settle_q <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef ALU_ISSUER_CHAIN_EN
            last_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
            op_q     <= op_d;
            err_q    <= err_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef ALU_ISSUER_CHAIN_EN
            last_q   <= last_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= {err_q, alu_out};
        end
    end

    assign alu_num1  = num1_q;
    assign alu_num2  = num2_q;
    assign alu_op    = op_q;
    assign op_count  = cnt_q;
    assign res_valid = (count_q != '0);
    assign res_data  = res_valid ? mem_q[rd_ptr_q][31:0] : '0;
    assign res_err   = res_valid ? mem_q[rd_ptr_q][32] : 1'b0;

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: directed vectors, corner sequences, and random traffic against a queue model.
module tb_alu_issuer;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [7:0]       cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic             cmd_chain = 1'b0;
    logic [7:0]       alu_num1;
    logic [31:0]      alu_num2;
    logic [2:0]       alu_op;
    logic [31:0]      alu_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic             res_err;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issuer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_ISSUER_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .op_count(op_count)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [31:0] b);
        logic [31:0] ax;
        ax = {24'd0, a};
        case (op)
            3'b000:  return ax + b;
            3'b001:  return ax - b;
            3'b010:  return ax & b;
            3'b011:  return ax | b;
            3'b100:  return ax ^ b;
            3'b101:  return (ax < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_out = alu_ref(alu_op, alu_num1, alu_num2);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a queue of results, one op in flight with an edge countdown.
    logic [32:0]      mq[$];
    bit               m_busy = 0;
    int               m_left = 0;
    logic [2:0]       m_op = '0;
    logic [7:0]       m_a = '0;
    logic [31:0]      m_num2 = '0;
    logic [31:0]      m_last = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_ready;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_res_err", res_err, 0);
            chk("rst_op_count", op_count, 0);
            chk("rst_alu_drive", {alu_num1, alu_num2, alu_op}, 0);
            mq.delete();
            m_busy = 0; m_op = '0; m_a = '0; m_num2 = '0; m_last = '0; m_cnt = '0;
        end else begin
            m_ready = !m_busy && (mq.size() < DEPTH);
            chk("cmd_ready", cmd_ready, m_ready);
            chk("res_valid", res_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("res_data", res_data, mq[0][31:0]);
                chk("res_err", res_err, mq[0][32]);
            end
            chk("op_count", op_count, m_cnt);
            chk("alu_drive", {alu_num1, alu_num2, alu_op}, {m_a, m_num2, m_op});
            if (mq.size() > DEPTH) chk("fifo_bound", mq.size(), DEPTH);
            if (mq.size() != 0 && res_ready) void'(mq.pop_front());
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_last = alu_ref(m_op, m_a, m_num2);
                    mq.push_back({(m_op >= 3'b110), m_last});
                    m_cnt++;
                    m_busy = 0;
                end
            end else if (cmd_valid && m_ready) begin
                m_busy = 1; m_left = SETTLE; m_op = cmd_op; m_a = cmd_a;
`ifdef ALU_ISSUER_CHAIN_EN
                m_num2 = cmd_chain ? m_last : cmd_b;
`else
                m_num2 = cmd_b;
`endif
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [31:0] b, input logic ch);
        bit hs;
        hs = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk); hs = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        if (!hs) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_result(input string name, input logic [31:0] ed, input logic ee);
        bit seen;
        seen = res_valid;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = res_valid;
        end
        chk({name, "_valid"}, seen, 1);
        chk({name, "_data"}, res_data, ed);
        chk({name, "_err"}, res_err, ee);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'b000, 8'h05, 32'h10,        32'h15,        1'b0};
        vecs[1] = '{3'b001, 8'h00, 32'h1,         32'hFFFFFFFF,  1'b0};
        vecs[2] = '{3'b101, 8'h03, 32'h7,         32'h1,         1'b0};
        vecs[3] = '{3'b110, 8'hFF, 32'h1,         32'h0,         1'b1};
        vecs[4] = '{3'b000, 8'h01, 32'h2,         32'h3,         1'b0};
        vecs[5] = '{3'b111, 8'h10, 32'h20,        32'h0,         1'b1};
        vecs[6] = '{3'b010, 8'hF0, 32'hFF,        32'hF0,        1'b0};
        vecs[7] = '{3'b100, 8'h0F, 32'hFFFF00FF,  32'hFFFF00F0,  1'b0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            wait_result("vec", vecs[i].exp_d, vecs[i].exp_e);
        end

        // Reset while an op is in flight.
        send(3'b000, 8'h05, 32'h10, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_num1", alu_num1, 0);
        chk("async_rst_cmd_ready", cmd_ready, 0);
        chk("async_rst_op_count", op_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", res_valid, 0);
        chk("post_rst_count", op_count, 0);
        chk("post_rst_ready", cmd_ready, 1);

        // Add with exact latency.
        send(3'b000, 8'h05, 32'h10, 1'b0);
        chk("lat_valid_early", res_valid, 0);
        @(posedge clk); #1;
        chk("lat_valid", res_valid, 1);
        chk("lat_data", res_data, 32'h15);
        chk("lat_count", op_count, 1);
        wait_result("lat", 32'h15, 1'b0);

        // Backpressure: four fill the FIFO, the fifth waits for a pop.
        for (int i = 0; i < 4; i++) send(3'b000, 8'(i), 32'd100, 1'b0);
        @(posedge clk); #1;
        chk("full_ready", cmd_ready, 0);
        chk("full_count", op_count, 5);
        cmd_op = 3'b000; cmd_a = 8'd4; cmd_b = 32'd100; cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("blocked_count", op_count, 5);
        chk("full_head", res_data, 32'd100);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        send(3'b000, 8'd4, 32'd100, 1'b0);
        for (int i = 1; i < 5; i++) wait_result("order", 32'd100 + 32'(i), 1'b0);
        chk("drained", res_valid, 0);

        // Push and pop on the same edge.
        send(3'b000, 8'd1, 32'd1, 1'b0);
        @(posedge clk); #1;
        send(3'b000, 8'd2, 32'd2, 1'b0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("pp_valid", res_valid, 1);
        chk("pp_data", res_data, 32'd4);
        wait_result("pp", 32'd4, 1'b0);
        chk("pp_empty", res_valid, 0);

`ifdef ALU_ISSUER_CHAIN_EN
        send(3'b000, 8'h05, 32'h10, 1'b0);
        send(3'b000, 8'h01, 32'hDEAD, 1'b1);
        chk("chain_num2", alu_num2, 32'h15);
        wait_result("chain_a", 32'h15, 1'b0);
        wait_result("chain_b", 32'h16, 1'b0);
`endif

        // Random traffic; the monitor compares every cycle.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op    = 3'($urandom);
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            cmd_chain = ($urandom_range(0, 2) == 0);
            res_ready = ($urandom_range(0, 4) < 3);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        res_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("final_empty", res_valid, 0);
        res_ready = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
